// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU request path: opcodes, sequencer
// states and the ALU result width.
package alu_pkg;

  localparam int ALU_W = 5;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_ROL   = 4'd10;
  localparam logic [3:0] OP_ROR   = 4'd11;
  localparam logic [3:0] OP_CMP   = 4'd12;
  localparam logic [3:0] OP_PASSA = 4'd13;
  localparam logic [3:0] OP_PASSB = 4'd14;
  localparam logic [3:0] OP_INC   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle between two requesters and the ALU sequencer.
// Requester i occupies nibble [4i+3:4i] of the packed operand/opcode fields.
interface alu_req_arbiter_if;
  import alu_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [7:0]       req_a;
  logic [7:0]       req_b;
  logic [7:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [ALU_W-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

endinterface

// File: rtl/alu_req_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// the requester that did not win last time.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Pick the winner and express it both as an index and one-hot
  always_comb begin
    grant     = '0;
    grant_idx = 1'b0;
    case (req)
      2'b01: begin grant = 2'b01; grant_idx = 1'b0; end
      2'b10: begin grant = 2'b10; grant_idx = 1'b1; end
      2'b11: begin
        grant_idx = ~last_grant;
        grant     = last_grant ? 2'b01 : 2'b10;
      end
      default: begin grant = '0; grant_idx = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin sequencer in front of the shared combinational 4-bit ALU.
// One operation in flight: accept in IDLE, sample ALU in EXEC, hold the
// tagged response in RESP until it is taken.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_req_arbiter_if.slave bus,
  output logic [15:0]      alu_sw,
  input  logic [ALU_W-1:0] alu_led,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_alu_sw;
  logic              r_rsp_id;
  logic [ALU_W-1:0]  r_rsp_result;
  logic              r_rsp_err;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_done_count;

  logic [NREQ-1:0]   w_grant;
  logic              w_grant_idx;
  logic [NREQ-1:0]   w_ready;
  logic              w_accept;
  logic              w_rsp_fire;
  logic              w_div0;
  logic [3:0]        w_a;
  logic [3:0]        w_b;
  logic [3:0]        w_op;

  rr_arbiter2 u_arb (
    .req        (bus.req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  // Fields of the granted requester, used only in the accept cycle
  always_comb begin
    w_a  = w_grant_idx ? bus.req_a[7:4]  : bus.req_a[3:0];
    w_b  = w_grant_idx ? bus.req_b[7:4]  : bus.req_b[3:0];
    w_op = w_grant_idx ? bus.req_op[7:4] : bus.req_op[3:0];
  end

  // Next state and request-side ready; ready only ever offered in IDLE
  always_comb begin
    w_next  = r_state;
    w_ready = '0;
    case (r_state)
      IDLE: begin
        w_ready = w_grant;
        if (|(bus.req_valid & w_grant)) w_next = EXEC;
      end
      EXEC: w_next = RESP;
      RESP: if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_accept   = (r_state == IDLE) && |(bus.req_valid & w_grant);
  assign w_rsp_fire = (r_state == RESP) && bus.rsp_ready;
  assign w_div0     = (r_alu_sw[11:8] == OP_DIV) && (r_alu_sw[7:4] == 4'd0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Capture the accepted request onto the ALU switch bus and tag it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_sw <= '0;
      r_rsp_id <= 1'b0;
    end else if (w_accept) begin
      r_alu_sw <= {4'h0, w_op, w_b, w_a};
      r_rsp_id <= w_grant_idx;
    end
  end

  // Sample the settled ALU result, substituting the divide-by-zero code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else if (r_state == EXEC) begin
      if (w_div0) begin
        r_rsp_result <= 5'h1F;
        r_rsp_err    <= 1'b1;
      end else begin
        r_rsp_result <= alu_led;
        r_rsp_err    <= 1'b0;
      end
    end
  end

  // Completion bookkeeping: count responses and remember who was served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_count <= '0;
      r_last_grant <= 1'b1;
    end else if (w_rsp_fire) begin
      r_done_count <= r_done_count + 1'b1;
      r_last_grant <= r_rsp_id;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_err    = r_rsp_err;
  assign alu_sw         = r_alu_sw;
  assign busy           = (r_state != IDLE);
  assign done_count     = r_done_count;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural stand-in for the ALU.
module tb_alu_req_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] alu_sw;
  logic [4:0]  alu_led;
  logic        busy;
  logic [7:0]  done_count;

  int checks;
  int errors;

  alu_req_arbiter_if bus();

  alu_req_arbiter #(.NREQ(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_sw     (alu_sw),
    .alu_led    (alu_led),
    .busy       (busy),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: divide by zero yields a junk value that must be ignored
  always_comb begin
    logic [3:0] a, b;
    a = alu_sw[3:0];
    b = alu_sw[7:4];
    case (alu_sw[11:8])
      4'd0:    alu_led = {1'b0, a} + {1'b0, b};
      4'd1:    alu_led = {(a >= b), a - b};
      4'd2:    alu_led = 5'(a * b);
      4'd3:    alu_led = (b == 4'd0) ? 5'h15 : {1'b0, a / b};
      default: alu_led = {1'b0, a ^ b};
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Drives one request from requester idx with rsp_ready high; starts and ends at a negedge
  task automatic send_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op, output bit ok, output logic id,
                         output logic [4:0] res, output logic err, output int lat);
    bit acc;
    acc = 0; ok = 0; lat = 0; id = 0; res = '0; err = 0;
    bus.req_a[idx*4 +: 4]  = a;
    bus.req_b[idx*4 +: 4]  = b;
    bus.req_op[idx*4 +: 4] = op;
    bus.req_valid          = '0;
    bus.req_valid[idx]     = 1'b1;
    bus.rsp_ready          = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.req_ready[idx]) begin acc = 1; break; end
      @(negedge clk);
    end
    if (!acc) begin
      bus.req_valid = '0;
      return;
    end
    @(negedge clk);
    bus.req_valid = '0;
    for (int c = 1; c < 8; c++) begin
      if (bus.rsp_valid) begin
        ok = 1; lat = c; id = bus.rsp_id; res = bus.rsp_result; err = bus.rsp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (alu_sw !== 16'h0000) begin errors++; $display("FAIL reset_alu_sw got %h exp 0000", alu_sw); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL reset_done_count got %0d exp 0", done_count); end
    checks++; if ({bus.rsp_id, bus.rsp_result, bus.rsp_err} !== 7'd0) begin
      errors++; $display("FAIL reset_rsp_fields got %b/%h/%b exp 0/00/0", bus.rsp_id, bus.rsp_result, bus.rsp_err); end
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b exp 01", bus.req_ready); end
    bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_add();
    bit ok; logic id; logic [4:0] res; logic err; int lat;
    send_op(0, 4'd9, 4'd8, 4'd0, ok, id, res, err, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_handshake got %b exp 1", ok); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
    checks++; if (id !== 1'b0) begin errors++; $display("FAIL add_id got %b exp 0", id); end
    checks++; if (res !== 5'h11) begin errors++; $display("FAIL add_result got %h exp 11", res); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", err); end
    checks++; if (done_count !== 8'd1) begin errors++; $display("FAIL add_done_count got %0d exp 1", done_count); end
    checks++; if (alu_sw !== 16'h0089) begin errors++; $display("FAIL add_alu_sw_held got %h exp 0089", alu_sw); end
  endtask

  task automatic test_sub();
    bit ok; logic id; logic [4:0] res; logic err; int lat;
    send_op(1, 4'd3, 4'd5, 4'd1, ok, id, res, err, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sub_handshake got %b exp 1", ok); end
    checks++; if (id !== 1'b1) begin errors++; $display("FAIL sub_id got %b exp 1", id); end
    checks++; if (res !== 5'h0E) begin errors++; $display("FAIL sub_result got %h exp 0e", res); end
    checks++; if (alu_sw !== 16'h0153) begin errors++; $display("FAIL sub_alu_sw got %h exp 0153", alu_sw); end
    checks++; if (done_count !== 8'd2) begin errors++; $display("FAIL sub_done_count got %0d exp 2", done_count); end
  endtask

  task automatic test_div_zero();
    bit ok; logic id; logic [4:0] res; logic err; int lat;
    send_op(0, 4'd7, 4'd0, 4'd3, ok, id, res, err, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL div0_handshake got %b exp 1", ok); end
    checks++; if (res !== 5'h1F) begin errors++; $display("FAIL div0_result got %h exp 1f", res); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL div0_err got %b exp 1", err); end
    send_op(0, 4'd12, 4'd3, 4'd3, ok, id, res, err, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL div_handshake got %b exp 1", ok); end
    checks++; if (res !== 5'h04) begin errors++; $display("FAIL div_result got %h exp 04", res); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL div_err got %b exp 0", err); end
    checks++; if (done_count !== 8'd4) begin errors++; $display("FAIL div_done_count got %0d exp 4", done_count); end
  endtask

  task automatic test_contention();
    int grants[6];
    int ids[6];
    logic [4:0] results[6];
    int ng, nr, both;
    ng = 0; nr = 0; both = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_a = 8'h21; bus.req_b = 8'h21; bus.req_op = 8'h00;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.req_ready == 2'b11) both++;
      if (bus.req_ready != 2'b00 && ng < 6) begin
        grants[ng] = bus.req_ready[1] ? 1 : 0;
        ng++;
      end
      if (bus.rsp_valid && nr < 6) begin
        ids[nr] = int'(bus.rsp_id);
        results[nr] = bus.rsp_result;
        nr++;
        if (nr == 6) begin
          bus.req_valid = 2'b00;
          @(negedge clk);
          break;
        end
      end
      @(negedge clk);
    end
    checks++; if (ng !== 6) begin errors++; $display("FAIL contention_grant_count got %0d exp 6", ng); end
    checks++; if (nr !== 6) begin errors++; $display("FAIL contention_rsp_count got %0d exp 6", nr); end
    checks++; if (both !== 0) begin errors++; $display("FAIL contention_double_ready got %0d exp 0", both); end
    for (int k = 0; k < 6; k++) begin
      if (k < ng) begin
        checks++; if (grants[k] !== k % 2) begin errors++; $display("FAIL contention_grant[%0d] got %0d exp %0d", k, grants[k], k % 2); end
      end
      if (k < nr) begin
        checks++; if (ids[k] !== k % 2) begin errors++; $display("FAIL contention_id[%0d] got %0d exp %0d", k, ids[k], k % 2); end
        checks++; if (results[k] !== ((k % 2 == 1) ? 5'h04 : 5'h02)) begin
          errors++; $display("FAIL contention_result[%0d] got %h exp %h", k, results[k], (k % 2 == 1) ? 5'h04 : 5'h02); end
      end
    end
    checks++; if (done_count !== 8'd6) begin errors++; $display("FAIL contention_done_count got %0d exp 6", done_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL contention_idle got busy %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    bus.req_a = 8'h05; bus.req_b = 8'h06; bus.req_op = 8'h00;
    bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept got %b exp 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d] got %b exp 1", c, bus.rsp_valid); end
      checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL bp_rsp_id[%0d] got %b exp 0", c, bus.rsp_id); end
      checks++; if (bus.rsp_result !== 5'h0B) begin errors++; $display("FAIL bp_rsp_result[%0d] got %h exp 0b", c, bus.rsp_result); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_req_ready[%0d] got %b exp 00", c, bus.req_ready); end
      checks++; if (done_count !== 8'd6) begin errors++; $display("FAIL bp_done_count[%0d] got %0d exp 6", c, done_count); end
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (done_count !== 8'd7) begin errors++; $display("FAIL bp_done_after got %0d exp 7", done_count); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_valid_after got %b exp 0", bus.rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    bus.req_a = 8'h40; bus.req_b = 8'h40; bus.req_op = 8'h00;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL rstmid_accept got %b exp 10", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_in_exec got busy %b exp 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (alu_sw !== 16'h0000) begin errors++; $display("FAIL rstmid_alu_sw got %h exp 0000", alu_sw); end
    checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL rstmid_done_count got %0d exp 0", done_count); end
    checks++; if ({bus.rsp_id, bus.rsp_result} !== 6'd0) begin errors++; $display("FAIL rstmid_rsp got %b/%h exp 0/00", bus.rsp_id, bus.rsp_result); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.rsp_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_response got %0d rsp cycles exp 0", seen); end
  endtask

  task automatic test_wrap();
    bit ok; logic id; logic [4:0] res; logic err; int lat;
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      send_op(k % 2, 4'(k), 4'd1, 4'd0, ok, id, res, err, lat);
      if (!ok) bad++;
      if (k == 254) begin
        checks++; if (done_count !== 8'd255) begin errors++; $display("FAIL wrap_pre got %0d exp 255", done_count); end
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_ops_lost got %0d exp 0", bad); end
    checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL wrap_done_count got %0d exp 0", done_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_div_zero();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
